// File: rtl/mcmem_io.sv
`default_nettype none
// ============================================================================
//  Module   : mcmem_io
//  Brief    : Memory/IO subsystem behind the multicycle CPU memory port.
//             Decodes madr into a word RAM, an interval timer and an 8N1
//             serial transmitter. Reads are combinational, writes on the edge.
//  Revision : 1.0  initial release
// ============================================================================
module mcmem_io #(
  parameter int RAM_AW       = 10,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] madr,
  input  logic [31:0] tomem,
  input  logic        wmem,
  output logic [31:0] frommem,
  output logic        tx,
  output logic        irq
);

  localparam logic [31:0] c_TXDATA = 32'hFFFF_FF00;
  localparam logic [31:0] c_TXSTAT = 32'hFFFF_FF04;
  localparam logic [31:0] c_TCOUNT = 32'hFFFF_FF10;
  localparam logic [31:0] c_TCMP   = 32'hFFFF_FF14;
  localparam logic [31:0] c_TCTRL  = 32'hFFFF_FF18;
  localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Storage and state
  logic [31:0] r_mem [0:(1<<RAM_AW)-1];
  logic [31:0] r_tcount;
  logic [31:0] r_tcmp;
  logic        r_en;
  logic        r_ie;
  logic        r_flag;
  state_t      r_state;
  logic [15:0] r_bitcnt;
  logic [2:0]  r_bitidx;
  logic [7:0]  r_shift;
  logic        r_tx;

  // Address decode; byte-lane bits are deliberately ignored
  logic [31:0]       w_addr;
  logic              w_unused_lsbs;
  logic              w_is_ram;
  logic [RAM_AW-1:0] w_ramidx;
  logic              w_busy;
  logic              w_match;
  logic              w_bit_end;
  logic              w_wr;

  assign w_addr        = {madr[31:2], 2'b00};
  assign w_unused_lsbs = ^madr[1:0];
  assign w_is_ram      = (madr[31:RAM_AW+2] == '0);
  assign w_ramidx      = madr[RAM_AW+1:2];
  assign w_busy        = (r_state != S_IDLE);
  assign w_match       = r_en && (r_tcount == r_tcmp);
  assign w_bit_end     = (r_bitcnt == c_BIT_LAST);
  // Reset blocks every write, RAM included
  assign w_wr          = wmem && !clr;

  assign tx  = r_tx;
  assign irq = r_flag & r_ie;

  // Combinational read mux
  always_comb begin
    frommem = 32'h0;
    if (w_is_ram) begin
      frommem = r_mem[w_ramidx];
    end else begin
      case (w_addr)
        c_TXSTAT: frommem = {31'h0, w_busy};
        c_TCOUNT: frommem = r_tcount;
        c_TCMP:   frommem = r_tcmp;
        c_TCTRL:  frommem = {29'h0, r_ie, r_flag, r_en};
        default:  frommem = 32'h0;
      endcase
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) begin
      r_mem[w_ramidx] <= tomem;
    end
  end

  // Interval timer: CPU writes to TCOUNT win over counting, flag set beats clear
  always_ff @(posedge clk) begin
    if (clr) begin
      r_tcount <= 32'h0;
      r_tcmp   <= 32'h0;
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      if (wmem && w_addr == c_TCOUNT) begin
        r_tcount <= tomem;
      end else if (r_en) begin
        r_tcount <= w_match ? 32'h0 : r_tcount + 32'h1;
      end
      if (wmem && w_addr == c_TCMP) begin
        r_tcmp <= tomem;
      end
      if (wmem && w_addr == c_TCTRL) begin
        r_en <= tomem[0];
        r_ie <= tomem[2];
      end
      if (w_match) begin
        r_flag <= 1'b1;
      end else if (wmem && w_addr == c_TCTRL && tomem[1]) begin
        r_flag <= 1'b0;
      end
    end
  end

  // 8N1 transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_bitcnt <= 16'h0;
      r_bitidx <= 3'h0;
      r_shift  <= 8'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wmem && w_addr == c_TXDATA) begin
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_shift  <= tomem[7:0];
            r_bitcnt <= 16'h0;
            r_bitidx <= 3'h0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state  <= S_DATA;
            r_tx     <= r_shift[0];
            r_bitcnt <= 16'h0;
          end else begin
            r_bitcnt <= r_bitcnt + 16'h1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bitcnt <= 16'h0;
            if (r_bitidx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitidx <= r_bitidx + 3'h1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end else begin
            r_bitcnt <= r_bitcnt + 16'h1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 16'h0;
          end else begin
            r_bitcnt <= r_bitcnt + 16'h1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcmem_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcmem_io
//  Brief    : Scoreboard bench for mcmem_io with a timeline-based reference
//             model (serial frame as an offset from its launch edge).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcmem_io;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] madr;
  logic [31:0] tomem;
  logic        wmem;
  logic [31:0] frommem;
  logic        tx;
  logic        irq;

  mcmem_io #(.RAM_AW(10), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .clr(clr), .madr(madr), .tomem(tomem), .wmem(wmem),
    .frommem(frommem), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] adr;
    logic [31:0] rd;
    logic        tx;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model state
  logic [31:0] m_ram [1024];
  logic [31:0] m_cnt, m_cmp;
  bit          m_en, m_ie, m_flag;
  int          m_d;      // edges since the current frame was launched
  logic [7:0]  m_byte;

  function automatic bit m_busy();
    return m_d < FRAME;
  endfunction

  function automatic logic m_tx();
    if (m_d < CPB) return 1'b0;
    if (m_d < 9 * CPB) return m_byte[(m_d / CPB) - 1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:12] == 20'h0) return m_ram[w[11:2]];
    case (w)
      32'hFFFF_FF04: return {31'h0, m_busy()};
      32'hFFFF_FF10: return m_cnt;
      32'hFFFF_FF14: return m_cmp;
      32'hFFFF_FF18: return {29'h0, m_ie, m_flag, m_en};
      default:       return 32'h0;
    endcase
  endfunction

  function automatic void m_step(input bit c, input logic [31:0] a,
                                 input logic [31:0] wd, input bit we);
    logic [31:0] w;
    bit          hit;
    w = {a[31:2], 2'b00};
    if (c) begin
      m_cnt = 0; m_cmp = 0; m_en = 0; m_ie = 0; m_flag = 0; m_d = FRAME;
      return;
    end
    hit = m_en && (m_cnt == m_cmp);
    if (we && w == 32'hFFFF_FF00 && !m_busy()) begin
      m_d = 0; m_byte = wd[7:0];
    end else if (m_d < FRAME) begin
      m_d++;
    end
    if (hit) m_flag = 1;
    else if (we && w == 32'hFFFF_FF18 && wd[1]) m_flag = 0;
    if (we && w == 32'hFFFF_FF10) m_cnt = wd;
    else if (m_en) m_cnt = hit ? 32'h0 : m_cnt + 1;
    if (we && w == 32'hFFFF_FF14) m_cmp = wd;
    if (we && w == 32'hFFFF_FF18) begin m_en = wd[0]; m_ie = wd[2]; end
    if (we && w[31:12] == 20'h0) m_ram[w[11:2]] = wd;
  endfunction

  // One bus cycle: drive, push expectation, advance the model on the edge
  task automatic cyc(input bit c, input logic [31:0] a, input logic [31:0] wd, input bit we);
    exp_t e;
    clr = c; madr = a; tomem = wd; wmem = we;
    e.cyc = cycle; e.adr = a; e.rd = m_read(a); e.tx = m_tx(); e.irq = m_flag & m_ie;
    q.push_back(e);
    @(posedge clk);
    m_step(c, a, wd, we);
    cycle++;
    #1;
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 3;
        if (frommem !== e.rd) begin
          failures++;
          $display("FAIL frommem cyc=%0d adr=%h got=%h exp=%h", e.cyc, e.adr, frommem, e.rd);
        end
        if (tx !== e.tx) begin
          failures++;
          $display("FAIL tx cyc=%0d got=%b exp=%b", e.cyc, tx, e.tx);
        end
        if (irq !== e.irq) begin
          failures++;
          $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, irq, e.irq);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return 32'($urandom_range(0, 63));
      3:       return 32'hFFFF_FF00;
      4:       return 32'hFFFF_FF04;
      5:       return 32'hFFFF_FF10;
      6:       return 32'hFFFF_FF14;
      7:       return 32'hFFFF_FF18 | 32'($urandom_range(0, 3));
      8:       return 32'h0000_1000;
      default: return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FF1C;
    endcase
  endfunction

  initial begin
    logic [31:0] a, d;
    bit          we;
    clr = 1'b1; madr = 0; tomem = 0; wmem = 0;
    repeat (2) @(posedge clk);
    m_step(1, 0, 0, 0);
    #1;
    for (int i = 0; i < 16; i++) cyc(0, 32'(i * 4), $urandom, 1);

    // RAM write/read and unmapped RAM-range address
    cyc(0, 32'h10, 32'hDEAD_BEEF, 1);
    cyc(0, 32'h10, 0, 0);
    cyc(0, 32'h13, 0, 0);
    cyc(0, 32'h14, 0, 0);
    cyc(0, 32'h1000, 0, 0);

    // Serial frame 0xA5, second write dropped mid-frame
    cyc(0, 32'hFFFF_FF00, 32'hA5, 1);
    for (int i = 0; i < 9; i++) cyc(0, 32'hFFFF_FF04, 0, 0);
    cyc(0, 32'hFFFF_FF00, 32'h3C, 1);
    for (int i = 0; i < 36; i++) cyc(0, 32'hFFFF_FF04, 0, 0);

    // Timer period and flag clear
    cyc(0, 32'hFFFF_FF14, 3, 1);
    cyc(0, 32'hFFFF_FF18, 32'b101, 1);
    for (int i = 0; i < 10; i++) cyc(0, 32'hFFFF_FF10, 0, 0);
    cyc(0, 32'hFFFF_FF18, 32'b111, 1);
    cyc(0, 32'hFFFF_FF18, 0, 0);

    // Clear on exactly the compare-match edge: set must win
    for (int i = 0; i < 8 && !(m_en && m_cnt == m_cmp); i++) cyc(0, 32'hFFFF_FF10, 0, 0);
    cyc(0, 32'hFFFF_FF18, 32'b111, 1);
    cyc(0, 32'hFFFF_FF18, 0, 0);

    // Reset mid-frame
    cyc(0, 32'hFFFF_FF00, 32'h5A, 1);
    for (int i = 0; i < 9; i++) cyc(0, 32'hFFFF_FF04, 0, 0);
    cyc(1, 32'h10, 32'h1234_5678, 1);
    cyc(0, 32'hFFFF_FF04, 0, 0);
    cyc(0, 32'hFFFF_FF10, 0, 0);
    cyc(0, 32'h10, 0, 0);

    // Writes to read-only and unmapped locations
    cyc(0, 32'hFFFF_FF00, 32'hFF, 1);
    cyc(0, 32'hFFFF_FF04, 32'hFFFF_FFFF, 1);
    cyc(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    cyc(0, 32'hFFFF_FF04, 0, 0);
    cyc(0, 32'h8000_0000, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a  = rand_addr();
      we = ($urandom_range(0, 9) < 3);
      d  = $urandom;
      if ({a[31:2], 2'b00} == 32'hFFFF_FF14 || {a[31:2], 2'b00} == 32'hFFFF_FF10)
        d = 32'($urandom_range(0, 20));
      if ({a[31:2], 2'b00} == 32'hFFFF_FF18 && $urandom_range(0, 3) != 0)
        d[0] = 1'b1;
      cyc(($urandom_range(0, 299) == 0), a, d, we);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcmem_io.md
# mcmem_io

Memory and I/O subsystem on the downstream side of the multicycle CPU's single memory port. It decodes the CPU's memory address and serves each access from one of three targets: a word-addressed RAM, a memory-mapped interval timer, or a memory-mapped 8N1 serial transmitter. Read data is combinational, so the CPU can latch it into its instruction or data register at the end of the same cycle. Writes take effect on the clock edge.

## Interface
Parameters:
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous, active-high.
- madr  input  32  byte address from the CPU; bits [1:0] are ignored.
- tomem  input  32  write data from the CPU.
- wmem  input  1  write enable, sampled at the rising edge.
- frommem  output  32  combinational read data for madr.
- tx  output  1  serial line; idles high.
- irq  output  1  timer interrupt, equal to flag & ie.

## Operation
Address map:
- RAM: madr[31:RAM_AW+2] == 0.
  - Word index is madr[RAM_AW+1:2].
  - Read is asynchronous; write on the edge when wmem is high.
  - RAM is not cleared by clr.
- 0xFFFF_FF00 TXDATA.
  - Write, when the serial FSM is in IDLE: latch tomem[7:0] and start a frame.
  - Write while busy: dropped with no side effect.
  - Read returns 0.
- 0xFFFF_FF04 TXSTAT: read {31'b0, busy}; writes ignored.
- 0xFFFF_FF10 TCOUNT: 32-bit counter, read/write.
- 0xFFFF_FF14 TCMP: 32-bit compare value, read/write.
- 0xFFFF_FF18 TCTRL, read {29'b0, ie, flag, en}.
  - Write sets en=tomem[0] and ie=tomem[2].
  - Writing tomem[1]=1 clears flag.
- Any other address: read returns 0; writes are ignored.

Timer, evaluated each edge with en=1:
- If TCOUNT == TCMP: TCOUNT <= 0 and flag <= 1.
- Otherwise TCOUNT <= TCOUNT+1, wrapping from 0xFFFF_FFFF to 0.
- A CPU write to TCOUNT overrides the update in that cycle.
- A flag-set event in the same cycle as a write-1-clear leaves flag=1 (set wins).
- With en=0, TCOUNT holds its value and flag changes only by clear.

Serial transmitter FSM. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) sequence it.
- IDLE: tx=1, busy=0. A TXDATA write moves to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit, 8 bits, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 in START, DATA and STOP.

Reset values, effective on the first edge with clr=1:
- tx=1, busy=0, FSM=IDLE, irq=0.
- TCOUNT=0, TCMP=0, en=0, ie=0, flag=0.
- frommem follows madr and current state at all times.
- clr mid-frame aborts the frame: tx=1 on the next cycle and the byte is lost.
- clr takes priority over every write.

## Timing
- Read latency is 0 cycles. frommem is combinational from madr and register state.
- Read-during-write on the same address: frommem shows the old value in that cycle and the new value from the next cycle.
- TXDATA write at edge N:
  - busy=1 and tx=0 from cycle N+1.
  - Data bit k drives cycles N+1+(k+1)·CLKS_PER_BIT through N+(k+2)·CLKS_PER_BIT.
  - Stop bit ends and busy=0 at N+1+10·CLKS_PER_BIT.
- A new TXDATA write is accepted on the same edge that FSM returns to IDLE only if busy already reads 0 before that edge.
- Timer period is TCMP+1 cycles. flag and irq assert the cycle after the edge where TCOUNT==TCMP.

## Test plan
- RAM write/read: write 0xDEADBEEF at 0x0000_0010, then read 0x10 and 0x13 → both return 0xDEADBEEF. Read 0x14 → returns that word's prior value. Address 0x0000_1000 with RAM_AW=10 → unmapped, returns 0.
- Serial frame: with CLKS_PER_BIT=4, write 0xA5 to 0xFFFF_FF00 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 for 40 cycles. A second write at cycle 10 is dropped.
- Timer: TCMP=3, TCTRL=0b101 → TCOUNT runs 0,1,2,3,0. irq=1 one cycle after TCOUNT=3. TCTRL write 0b111 clears flag.
- Set-vs-clear race: write-1-clear exactly on the compare-match edge → flag remains 1.
- Reset mid-frame: assert clr 10 cycles into a frame → next cycle tx=1, TXSTAT reads 0, TCOUNT=0. RAM contents are unchanged.
- Unmapped and read-only writes: write to 0xFFFF_FF04 and 0x8000_0000 → no state change; both read 0 except TXSTAT busy.
